// File: rtl/alu_share_arb.sv
// Round-robin front end that time-shares one combinational ALU between NREQ requesters.
// Define ALU_SHARE_ARB_RR_EN for round-robin; otherwise fixed priority (lowest index wins).
module alu_share_arb #(
   parameter int n    = 4,
   parameter int NREQ = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ*n-1:0]   req_a,
   input  logic [NREQ*n-1:0]   req_b,
   input  logic [NREQ*3-1:0]   req_sel,
   output logic [n-1:0]        alu_a,
   output logic [n-1:0]        alu_b,
   output logic [2:0]          alu_sel,
   input  logic [n-1:0]        alu_s,
   input  logic                alu_co,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [n-1:0]        rsp_s,
   output logic                rsp_co,
   output logic [2:0]          rsp_id,
   output logic                busy,
   output logic [7:0]          op_cnt
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]      state;
   logic [2:0]      ptr;
   logic [7:0]      vld8;
   logic [3:0]      idx;
   logic [2:0]      gidx;
   logic            gfound;
   logic [NREQ-1:0] grant;
   logic            accept;
   logic [n-1:0]    pick_a;
   logic [n-1:0]    pick_b;
   logic [2:0]      pick_sel;
   logic [2:0]      ptr_next;

   assign vld8 = 8'(req_valid);

   // Search starts at ptr and wraps; with ptr pinned at 0 this degenerates to fixed priority.
   always_comb begin
      idx    = 4'd0;
      gidx   = 3'd0;
      gfound = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = {1'b0, ptr} + 4'(k);
         if (idx >= 4'(NREQ))
            idx = idx - 4'(NREQ);
         if (!gfound && vld8[idx[2:0]]) begin
            gfound = 1'b1;
            gidx   = idx[2:0];
         end
      end
   end

   always_comb begin
      grant    = '0;
      pick_a   = '0;
      pick_b   = '0;
      pick_sel = 3'd0;
      for (int k = 0; k < NREQ; k++) begin
         grant[k] = gfound && (gidx == 3'(k));
         if (gidx == 3'(k)) begin
            pick_a   = req_a[k*n +: n];
            pick_b   = req_b[k*n +: n];
            pick_sel = req_sel[k*3 +: 3];
         end
      end
   end

   assign ptr_next  = (gidx == 3'(NREQ-1)) ? 3'd0 : gidx + 3'd1;
   assign req_ready = (rst_n && state == IDLE) ? grant : '0;
   assign accept    = rst_n && (state == IDLE) && gfound;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= 3'd0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_sel   <= 3'd0;
         rsp_valid <= 1'b0;
         rsp_s     <= '0;
         rsp_co    <= 1'b0;
         rsp_id    <= 3'd0;
         op_cnt    <= 8'd0;
      end else begin
         case (state)
            // Issue: operands latched here stay on the ALU through EXEC and beyond.
            IDLE: begin
               if (accept) begin
                  alu_a   <= pick_a;
                  alu_b   <= pick_b;
                  alu_sel <= pick_sel;
                  rsp_id  <= gidx;
`ifdef ALU_SHARE_ARB_RR_EN
                  ptr     <= ptr_next;
`else
                  ptr     <= 3'd0;
`endif
                  state   <= EXEC;
               end
            end
            // Capture: the ALU has had a full cycle to settle on the registered operands.
            EXEC: begin
               rsp_s     <= alu_s;
               rsp_co    <= alu_co;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            // Return: hold the response until the consumer takes it.
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  op_cnt    <= op_cnt + 8'd1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
